// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file: default geometry, the
// clear-sequencer state type and lane addressing.
package vrf_pkg;

   localparam int unsigned DEF_DATA_W   = 16;
   localparam int unsigned DEF_LANES    = 4;
   localparam int unsigned DEF_NUM_REGS = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DONE
   } clr_state_e;

   // Low bit index of a lane inside a packed vector word.
   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned data_w);
      return lane * data_w;
   endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register busy scoreboard: reservations set a bit, writes clear it,
// and a clear sweep start wipes the whole vector.
module vrf_scoreboard
   import vrf_pkg::*;
#(
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter int unsigned AW       = $clog2(NUM_REGS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_i,
   input  logic [AW-1:0] wa_i,
   input  logic          rsv_i,
   input  logic [AW-1:0] rsv_a_i,
   input  logic          clr_i,
   input  logic [AW-1:0] rs_i [3],
   output logic [2:0]    busy_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;

   // Reserve is applied after the write so it wins on an address collision.
   always_comb begin
      busy_d = busy_q;
      if (wr_i)  busy_d[wa_i]    = 1'b0;
      if (rsv_i) busy_d[rsv_a_i] = 1'b1;
      if (clr_i) busy_d          = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   always_comb begin
      busy_o = '0;
      for (int unsigned p = 0; p < 3; p++) begin
         busy_o[p] = busy_q[rs_i[p]]
                   & ~(wr_i & (wa_i == rs_i[p]) & ~(rsv_i & (rsv_a_i == rs_i[p])));
      end
   end

endmodule

// File: rtl/vector_rf.sv
// Vector register file: three combinational read ports with write-through
// bypass, one lane-masked write port, busy scoreboard and a clear sweep.
module vector_rf
   import vrf_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned LANES    = DEF_LANES,
   parameter int unsigned NUM_REGS = DEF_NUM_REGS,
   parameter bit          ZERO_R0  = 1'b0,
   parameter int unsigned AW       = $clog2(NUM_REGS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AW-1:0]           RS1,
   input  logic [AW-1:0]           RS2,
   input  logic [AW-1:0]           RS3,
   output logic [LANES*DATA_W-1:0] RD1,
   output logic [LANES*DATA_W-1:0] RD2,
   output logic [LANES*DATA_W-1:0] RD3,
   output logic                    BUSY1,
   output logic                    BUSY2,
   output logic                    BUSY3,
   input  logic                    WE,
   input  logic [AW-1:0]           WA,
   input  logic [LANES-1:0]        WMASK,
   input  logic [LANES*DATA_W-1:0] WD,
   output logic                    WR_READY,
   input  logic                    RSV,
   input  logic [AW-1:0]           RSV_A,
   input  logic                    CLR_REQ,
   output logic                    CLR_BUSY,
   output logic                    CLR_DONE
);

   localparam int unsigned W = LANES * DATA_W;

   logic [W-1:0]  mem_q [NUM_REGS];
   clr_state_e    state_q;
   logic [AW-1:0] cnt_q;

   logic          wr_ready, wr_eff, rsv_eff, clr_start;
   logic [AW-1:0] rs [3];
   logic [W-1:0]  rd [3];
   logic [2:0]    busy;

   function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                          input logic [W-1:0] new_v,
                                          input logic [LANES-1:0] mask);
      logic [W-1:0] r;
      r = old_v;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (mask[l]) r[lane_lo(l, DATA_W) +: DATA_W] = new_v[lane_lo(l, DATA_W) +: DATA_W];
      end
      return r;
   endfunction

   assign rs[0] = RS1;
   assign rs[1] = RS2;
   assign rs[2] = RS3;

   // Register 0 traffic is dropped here so storage and scoreboard never see it.
   assign wr_ready  = (state_q != ST_CLEAR);
   assign wr_eff    = WE  & wr_ready & ~(ZERO_R0 & (WA == '0));
   assign rsv_eff   = RSV & wr_ready & ~(ZERO_R0 & (RSV_A == '0));
   assign clr_start = CLR_REQ & wr_ready;

   always_comb begin
      for (int unsigned p = 0; p < 3; p++) begin
         rd[p] = mem_q[rs[p]];
         if (wr_eff && (rs[p] == WA)) rd[p] = merge(mem_q[rs[p]], WD, WMASK);
         if (ZERO_R0 && (rs[p] == '0)) rd[p] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         if (wr_eff) mem_q[WA] <= merge(mem_q[WA], WD, WMASK);
         case (state_q)
            ST_IDLE: begin
               if (CLR_REQ) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end
            end
            ST_CLEAR: begin
               mem_q[cnt_q] <= '0;
               cnt_q        <= cnt_q + AW'(1);
               if (cnt_q == AW'(NUM_REGS - 1)) state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (CLR_REQ) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   vrf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_sb (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr_i    (wr_eff),
      .wa_i    (WA),
      .rsv_i   (rsv_eff),
      .rsv_a_i (RSV_A),
      .clr_i   (clr_start),
      .rs_i    (rs),
      .busy_o  (busy)
   );

   assign RD1      = rd[0];
   assign RD2      = rd[1];
   assign RD3      = rd[2];
   assign BUSY1    = busy[0];
   assign BUSY2    = busy[1];
   assign BUSY3    = busy[2];
   assign WR_READY = wr_ready;
   assign CLR_BUSY = (state_q == ST_CLEAR);
   assign CLR_DONE = (state_q == ST_DONE);

endmodule

// File: doc/vector_rf.md
Name: vector_rf

Overview:
- Parametrised successor to the scalar register file: NUM_REGS entries, each LANES x DATA_W bits, with three combinational read ports and one lane-masked write port.
- Adds write-through bypass, a per-register busy scoreboard for pipeline hazard detection, and a multi-cycle clear sequencer.
- Sits in the vector datapath between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 16, bits per lane element
- LANES, 4, elements per vector register
- NUM_REGS, 32, register count (power of two, >=2)
- ZERO_R0, 0, 1 = register 0 reads zero, ignores writes, never busy
- AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- RS1, RS2, RS3  in  AW  read addresses
- RD1, RD2, RD3  out  LANES*DATA_W  read data; lane i at bits [i*DATA_W +: DATA_W]
- BUSY1, BUSY2, BUSY3  out  1  scoreboard status of RS1..RS3
- WE  in  1  write request
- WA  in  AW  write address
- WMASK  in  LANES  per-lane write enable
- WD  in  LANES*DATA_W  write data
- WR_READY  out  1  write/reserve accepted this cycle (0 while clearing)
- RSV  in  1  reserve request: set busy bit of RSV_A
- RSV_A  in  AW  register to reserve
- CLR_REQ  in  1  start clear sweep
- CLR_BUSY  out  1  sweep in progress
- CLR_DONE  out  1  one-cycle pulse after the last entry is cleared

Behaviour:
- Reset, checked at the clock edge (synchronous): every storage lane = 0, every busy bit = 0, FSM = IDLE, sweep counter = 0. Outputs after reset: RD* = 0, BUSY* = 0, WR_READY = 1, CLR_BUSY = 0, CLR_DONE = 0. Reset wins over every other input and aborts a sweep mid-operation.
- Reads are combinational, zero latency.
- Write acceptance: a write is accepted when WE & WR_READY. On the next edge, lanes with WMASK[i]=1 take WD lane i; unmasked lanes hold. WMASK=0 still counts as an accepted write, so the busy bit clears.
- Bypass: if a write is accepted and RSx == WA, RDx lane i = WD lane i where WMASK[i]=1, otherwise the stored lane.
- Scoreboard set/clear: an accepted write clears busy[WA]. An accepted reserve (RSV & WR_READY) sets busy[RSV_A]. If both target the same address in one cycle, the reserve wins and the bit stays 1.
- BUSYx = busy[RSx] & ~(accepted write to RSx this cycle & no accepted reserve to RSx this cycle). This is combinational.
- ZERO_R0=1: RDx = 0 and BUSYx = 0 whenever RSx = 0. Writes and reserves to register 0 are dropped.
- FSM IDLE -> CLEAR on CLR_REQ. On the accepting edge: all busy bits = 0, counter = 0. A same-cycle write or reserve is still accepted and applied first, then the clear overrides it.
- In CLEAR:
  - Each cycle, entry[counter] = 0 (all lanes) and counter increments.
  - CLR_BUSY = 1 and WR_READY = 0; WE and RSV are ignored.
  - CLR_REQ is ignored.
  - Reads return stored contents (already-swept entries read 0). No bypass.
- CLEAR ends when counter == NUM_REGS-1 is cleared: that edge moves the FSM to DONE.
- DONE lasts one cycle: CLR_DONE = 1, CLR_BUSY = 0, WR_READY = 1. It returns to IDLE, or re-enters CLEAR if CLR_REQ = 1.
- Sweep latency: NUM_REGS cycles of CLR_BUSY, then the CLR_DONE pulse.

Decomposition:
- Package vrf_pkg holds:
  - the FSM state enum (IDLE, CLEAR, DONE)
  - the lane slice helper function
  - default DATA_W/LANES/NUM_REGS constants
- One sub-module, vrf_scoreboard: busy bit vector, set/clear priority, BUSYx generation.
- Storage, bypass and the clear FSM stay in vector_rf.

Test Plan:
- Reset, then write WA=5, WMASK=4'b1111, WD={16'h4444,16'h3333,16'h2222,16'h1111}. Next cycle RS1=5 -> RD1 = same value. Then write WA=5, WMASK=4'b0010, WD lane1=16'hBEEF -> RD1 = {4444,3333,BEEF,1111}.
- Bypass: WE=1, WA=7, WMASK=4'b0101, WD all lanes 16'hAAAA, with RS2=7 in the same cycle while storage is 0 -> RD2 = {0000,AAAA,0000,AAAA} in that cycle.
- Scoreboard:
  - RSV=1, RSV_A=9 -> next cycle RS3=9 gives BUSY3 = 1.
  - Write WA=9 -> BUSY3 = 0 in the write cycle and after it.
  - RSV and WE both to 9 in one cycle -> busy stays 1.
- Clear sweep, NUM_REGS=32, regs 0..31 loaded with nonzero values, CLR_REQ pulse:
  - CLR_BUSY = 1 for exactly 32 cycles; a WE=1 issued during the sweep is dropped.
  - CLR_DONE pulses once.
  - Afterwards every RD = 0 and every BUSY = 0.
- Reset mid-clear at cycle 10 of the sweep -> next cycle FSM is IDLE, WR_READY = 1, CLR_DONE is never asserted, all registers read 0.
- ZERO_R0=1: write WA=0, WD=16'hFFFF lanes, then RSV_A=0 -> RS1=0 gives RD1 = 0 and BUSY1 = 0.
